// File: rtl/mc_control_unit_if.sv
// Memory handshake between the multicycle controller (master) and the memory system (slave).
interface mc_control_unit_if;
   logic mem_req;
   logic mem_write;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_write, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM with memory wait timeout and retired-instruction counter.
// Optional feature: define MC_CTRL_EXT_BRANCH_EN to add bne/blez.
module mc_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mc_control_unit_if.master    mem,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 a_sign,
   input  logic                 a_nonzero,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 alu_src_a,
   output logic                 pc_en,
   output logic                 imm_zext,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           pc_src,
   output logic [2:0]           alu_control,
   output logic                 halted,
   output logic                 error,
   output logic                 illegal,
   output logic [CNT_W-1:0]     instr_count
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;
`ifdef MC_CTRL_EXT_BRANCH_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
      S_ALUWB, S_IMMEXEC, S_IMMWB, S_BRANCH, S_JUMP, S_HALT, S_ERROR
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       imm_zext;
      logic       halted;
      logic       error;
   } ctrl_t;

   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic imm_zext_op(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   // An illegal instruction dispatches back to FETCH; that is the only DECODE exit to FETCH.
   function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_LW, OP_SW:             return S_MEMADR;
         OP_RTYPE:                 return funct_legal(fn) ? S_RTEXEC : S_FETCH;
         OP_ADDI, OP_ANDI, OP_ORI: return S_IMMEXEC;
         OP_BEQ, OP_BGTZ:          return S_BRANCH;
`ifdef MC_CTRL_EXT_BRANCH_EN
         OP_BNE, OP_BLEZ:          return S_BRANCH;
`endif
         OP_J:                     return S_JUMP;
         OP_HALT:                  return S_HALT;
         default:                  return S_FETCH;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [5:0] op, input logic z,
                                         input logic sgn, input logic nz);
      case (op)
         OP_BEQ:  return z;
         OP_BGTZ: return ~sgn & nz;
`ifdef MC_CTRL_EXT_BRANCH_EN
         OP_BNE:  return ~z;
         OP_BLEZ: return sgn | ~nz;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op,
                                      input logic [5:0] fn);
      ctrl_t c;
      c             = '0;
      c.alu_control = ALU_ADD;
      case (s)
         S_FETCH:   begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
         S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEMWR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
         S_RTEXEC:  begin c.alu_src_a = 1'b1; c.alu_control = funct_alu(fn); end
         S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_IMMEXEC: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = 2'b10;
            c.alu_control = imm_alu(op);
            c.imm_zext    = imm_zext_op(op);
         end
         S_IMMWB:   begin c.reg_write = 1'b1; c.imm_zext = imm_zext_op(op); end
         S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_src = 2'b01; end
         S_JUMP:    c.pc_src = 2'b10;
         S_HALT:    c.halted = 1'b1;
         S_ERROR:   c.error = 1'b1;
         default:   c.error = 1'b1;
      endcase
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   ctrl_t            ctrl_q;
   logic             mem_wait_s;
   logic             pc_en_s;

   // Next state, memory wait counter and timeout escape.
   always_comb begin
      state_d    = state_q;
      mem_wait_s = 1'b0;
      wait_d     = 8'd0;
      case (state_q)
         S_FETCH: begin
            if (mem.mem_ready) state_d = S_DECODE;
            else               mem_wait_s = 1'b1;
         end
         S_DECODE:  state_d = dispatch(opcode, funct);
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem.mem_ready) state_d = S_MEMWB;
            else               mem_wait_s = 1'b1;
         end
         S_MEMWR: begin
            if (mem.mem_ready) state_d = S_FETCH;
            else               mem_wait_s = 1'b1;
         end
         S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_RTEXEC:  state_d = S_ALUWB;
         S_IMMEXEC: state_d = S_IMMWB;
         S_HALT:    state_d = S_HALT;
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_ERROR;
      endcase
      if (mem_wait_s) begin
         if (wait_q == WAIT_LAST) state_d = S_ERROR;
         else                     wait_d  = wait_q + 8'd1;
      end else begin
         wait_d = 8'd0;
      end
   end

   // Retire count: every arrival in FETCH except from FETCH itself or an illegal DECODE.
   always_comb begin
      if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE))
         instr_count_d = instr_count_q + CNT_W'(1);
      else
         instr_count_d = instr_count_q;
   end

   // State, counters and the Moore outputs of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_FETCH;
         wait_q        <= 8'd0;
         instr_count_q <= '0;
         ctrl_q        <= ctrl_for(S_FETCH, OP_RTYPE, FN_ADD);
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         instr_count_q <= instr_count_d;
         ctrl_q        <= ctrl_for(state_d, opcode, funct);
      end
   end

   // PC enable depends on same-cycle mem_ready and ALU flags, so it cannot be registered.
   always_comb begin
      case (state_q)
         S_FETCH:  pc_en_s = mem.mem_ready;
         S_BRANCH: pc_en_s = branch_taken(opcode, zero, a_sign, a_nonzero);
         S_JUMP:   pc_en_s = 1'b1;
         default:  pc_en_s = 1'b0;
      endcase
   end

   assign pc_en    = pc_en_s & ~rst;
   assign ir_write = (state_q == S_FETCH) & mem.mem_ready & ~rst;
   assign illegal  = (state_q == S_DECODE) & (dispatch(opcode, funct) == S_FETCH) & ~rst;

   assign mem.mem_req   = ctrl_q.mem_req;
   assign mem.mem_write = ctrl_q.mem_write;
   assign mem.iord      = ctrl_q.iord;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_control   = ctrl_q.alu_control;
   assign pc_src        = ctrl_q.pc_src;
   assign reg_write     = ctrl_q.reg_write;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign imm_zext      = ctrl_q.imm_zext;
   assign halted        = ctrl_q.halted;
   assign error         = ctrl_q.error;
   assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: instruction flows, memory waits, timeout, reset abort, halt.
module tb_mc_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero, a_sign, a_nonzero;
   logic        ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, imm_zext;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alu_control;
   logic        halted, error, illegal;
   logic [15:0] instr_count;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          exp_cnt = 0;

   mc_control_unit_if mem_if ();

   mc_control_unit #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mem(mem_if),
      .opcode(opcode), .funct(funct),
      .zero(zero), .a_sign(a_sign), .a_nonzero(a_nonzero),
      .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .pc_en(pc_en),
      .imm_zext(imm_zext), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .halted(halted), .error(error),
      .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FETCH with memory ready this cycle; ends in DECODE with the new instruction on opcode/funct.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      mem_if.mem_ready = 1'b1;
      opcode = op;
      funct  = fn;
      #1;
      chk("fetch_ir_write", ir_write, 1);
      chk("fetch_pc_en", pc_en, 1);
      tick();
      mem_if.mem_ready = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; mem_if.mem_ready = 1'b0;
      opcode = 6'd0; funct = 6'd0; zero = 1'b0; a_sign = 1'b0; a_nonzero = 1'b0;
      repeat (2) tick();
      chk("rst_count", instr_count, 0);
      chk("rst_mem_write", mem_if.mem_write, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_halted", halted, 0);
      chk("rst_error", error, 0);
      chk("rst_illegal", illegal, 0);
      mem_if.mem_ready = 1'b1;
      #1;
      chk("rst_ir_write_gated", ir_write, 0);
      chk("rst_pc_en_gated", pc_en, 0);
      mem_if.mem_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk("fetch_mem_req", mem_if.mem_req, 1);
      chk("fetch_alu_src_b", alu_src_b, 2'b01);

      // add: FETCH, DECODE, RTEXEC, ALUWB
      fetch(6'b000000, 6'b100000);
      mem_if.mem_ready = 1'b1;
      #1;
      chk("dec_alu_src_b", alu_src_b, 2'b11);
      chk("dec_ready_ignored", ir_write, 0);
      chk("dec_illegal_add", illegal, 0);
      tick();
      mem_if.mem_ready = 1'b0;
      chk("rt_alu_src_a", alu_src_a, 1);
      chk("rt_alu_src_b", alu_src_b, 2'b00);
      chk("rt_alu_add", alu_control, 3'b010);
      tick();
      chk("aluwb_reg_write", reg_write, 1);
      chk("aluwb_reg_dst", reg_dst, 1);
      chk("aluwb_mem_to_reg", mem_to_reg, 0);
      chk("aluwb_count", instr_count, 0);
      tick();
      exp_cnt = 1;
      chk("add_count", instr_count, exp_cnt);
      chk("add_back_fetch", mem_if.mem_req, 1);

      // lw with three wait cycles in MEMRD
      fetch(6'b100011, 6'b000000);
      tick();
      chk("memadr_src_a", alu_src_a, 1);
      chk("memadr_src_b", alu_src_b, 2'b10);
      tick();
      chk("memrd_req", mem_if.mem_req, 1);
      chk("memrd_iord", mem_if.iord, 1);
      repeat (3) tick();
      chk("memrd_held_iord", mem_if.iord, 1);
      chk("memrd_no_error", error, 0);
      mem_if.mem_ready = 1'b1;
      tick();
      mem_if.mem_ready = 1'b0;
      chk("memwb_reg_write", reg_write, 1);
      chk("memwb_mem_to_reg", mem_to_reg, 1);
      chk("memwb_reg_dst", reg_dst, 0);
      chk("memwb_mem_req", mem_if.mem_req, 0);
      tick();
      exp_cnt = 2;
      chk("lw_count", instr_count, exp_cnt);

      // ori: zero-extended OR immediate
      fetch(6'b001101, 6'b000000);
      tick();
      chk("imm_alu_or", alu_control, 3'b001);
      chk("imm_zext", imm_zext, 1);
      chk("imm_src_b", alu_src_b, 2'b10);
      tick();
      chk("immwb_reg_write", reg_write, 1);
      chk("immwb_zext_held", imm_zext, 1);
      chk("immwb_reg_dst", reg_dst, 0);
      tick();
      exp_cnt = 3;
      chk("ori_count", instr_count, exp_cnt);

      // bgtz taken, then not taken when A is zero
      a_sign = 1'b0; a_nonzero = 1'b1;
      fetch(6'b000111, 6'b000000);
      tick();
      chk("bgtz_pc_en", pc_en, 1);
      chk("bgtz_pc_src", pc_src, 2'b01);
      chk("bgtz_alu_sub", alu_control, 3'b110);
      a_nonzero = 1'b0;
      #1;
      chk("bgtz_zero_pc_en", pc_en, 0);
      tick();
      exp_cnt = 4;
      chk("bgtz_count", instr_count, exp_cnt);

      // beq follows zero
      zero = 1'b1;
      fetch(6'b000100, 6'b000000);
      tick();
      chk("beq_taken", pc_en, 1);
      zero = 1'b0;
      #1;
      chk("beq_not_taken", pc_en, 0);
      tick();
      exp_cnt = 5;
      chk("beq_count", instr_count, exp_cnt);

      // opcode 000101: bne when the extension is built, illegal otherwise
      fetch(6'b000101, 6'b000000);
`ifdef MC_CTRL_EXT_BRANCH_EN
      chk("bne_not_illegal", illegal, 0);
      tick();
      chk("bne_pc_en", pc_en, 1);
      tick();
      exp_cnt = 6;
`else
      chk("op5_illegal", illegal, 1);
      chk("op5_pc_en", pc_en, 0);
      chk("op5_reg_write", reg_write, 0);
      tick();
      chk("op5_illegal_cleared", illegal, 0);
`endif
      chk("op5_count", instr_count, exp_cnt);
      chk("op5_back_fetch", mem_if.mem_req, 1);

      // R-type with unsupported funct
      fetch(6'b000000, 6'b000000);
      chk("badfn_illegal", illegal, 1);
      tick();
      chk("badfn_count", instr_count, exp_cnt);

      // jump
      fetch(6'b000010, 6'b000000);
      tick();
      chk("jump_pc_en", pc_en, 1);
      chk("jump_pc_src", pc_src, 2'b10);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("jump_count", instr_count, exp_cnt);

      // sw aborted by reset while waiting on memory
      fetch(6'b101011, 6'b000000);
      tick();
      tick();
      chk("memwr_write", mem_if.mem_write, 1);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_write", mem_if.mem_write, 0);
      chk("abort_count", instr_count, 0);
      chk("abort_iord", mem_if.iord, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("fresh_fetch_req", mem_if.mem_req, 1);
      chk("fresh_fetch_iord", mem_if.iord, 0);

      // timeout in FETCH with memory never ready
      repeat (14) tick();
      chk("to_still_fetch", mem_if.mem_req, 1);
      chk("to_not_yet_error", error, 0);
      tick();
      chk("to_error", error, 1);
      chk("to_mem_req_off", mem_if.mem_req, 0);
      mem_if.mem_ready = 1'b1;
      tick();
      chk("to_error_sticky", error, 1);
      chk("to_no_ir_write", ir_write, 0);
      mem_if.mem_ready = 1'b0;

      // halt is absorbing
      rst = 1'b1;
      tick();
      chk("rst_clears_error", error, 0);
      rst = 1'b0;
      #1;
      fetch(6'b111111, 6'b000000);
      tick();
      chk("halt_halted", halted, 1);
      chk("halt_reg_write", reg_write, 0);
      chk("halt_mem_req", mem_if.mem_req, 0);
      mem_if.mem_ready = 1'b1;
      tick();
      chk("halt_sticky", halted, 1);
      chk("halt_no_ir_write", ir_write, 0);
      chk("halt_count", instr_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
